// File: rtl/prefix_pkg.sv
// rtl/prefix_pkg.sv - geometry helpers for the pipelined Kogge-Stone adder
package prefix_pkg;

    // Number of prefix levels needed to span value bit positions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Number of prefix-network stages (each followed by a register).
    function automatic int num_stages(input int width, input int lvl_per_stg);
        return (clog2(width) + lvl_per_stg - 1) / lvl_per_stg;
    endfunction

    // First prefix level evaluated by network stage stg (0-based; it sits
    // between pipeline register stg and stg+1).
    function automatic int stage_first_level(input int stg, input int lvl_per_stg);
        return stg * lvl_per_stg;
    endfunction

    // Levels actually evaluated by network stage stg; the last one may be short.
    function automatic int stage_num_levels(input int width, input int stg, input int lvl_per_stg);
        int n;
        n = clog2(width) - stg * lvl_per_stg;
        if (n > lvl_per_stg) n = lvl_per_stg;
        if (n < 0) n = 0;
        return n;
    endfunction

endpackage

// File: rtl/prefix_gp_cell.sv
// rtl/prefix_gp_cell.sv - Kogge-Stone black cell; GRAY=1 drops the P output
module prefix_gp_cell #(
    parameter bit GRAY = 1'b0
) (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_o,
    output logic p_o
);

    assign g_o = g_hi | (p_hi & g_lo);

    // Once a span reaches bit 0 its propagate is never consumed again.
    if (GRAY) begin : g_gray
        assign p_o = 1'b0;
    end else begin : g_black
        assign p_o = p_hi & p_lo;
    end

endmodule

// File: rtl/prefix_adder_pipe.sv
// rtl/prefix_adder_pipe.sv - pipelined Kogge-Stone adder, valid/ready; PREFIX_ADDER_SUB_EN adds in_sub
module prefix_adder_pipe
    import prefix_pkg::*;
#(
    parameter int WIDTH       = 48,
    parameter int LVL_PER_STG = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef PREFIX_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NSTG = num_stages(WIDTH, LVL_PER_STG);

    // Registers 0..NSTG-1 hold (G,P) plus the raw per-bit propagate and cin
    // needed for the final sum; register NSTG is the output register.
    logic [WIDTH-1:0] g_q  [NSTG];
    logic [WIDTH-1:0] g_d  [NSTG];
    logic [WIDTH-1:0] p_q  [NSTG];
    logic [WIDTH-1:0] p_d  [NSTG];
    logic [WIDTH-1:0] pt_q [NSTG];
    logic [WIDTH-1:0] pt_d [NSTG];
    logic [NSTG-1:0]  cin_q, cin_d;
    logic [NSTG:0]    v_q, v_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] lg [NSTG][LVL_PER_STG+1];
    logic [WIDTH-1:0] lp [NSTG][LVL_PER_STG+1];

    logic [WIDTH-1:0] b_eff, g0, p0, carry, sum_fin;
    logic             c_eff, adv;

    assign adv       = !v_q[NSTG] | out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[NSTG];
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

    // Bit-level generate/propagate; carry-in is merged into bit 0's generate.
    always_comb begin
`ifdef PREFIX_ADDER_SUB_EN
        b_eff = in_sub ? ~in_b : in_b;
        c_eff = in_sub ? 1'b1 : in_cin;
`else
        b_eff = in_b;
        c_eff = in_cin;
`endif
        g0    = in_a & b_eff;
        p0    = in_a ^ b_eff;
        g0[0] = g0[0] | (p0[0] & c_eff);
    end

    for (genvar s = 0; s < NSTG; s++) begin : g_stg
        localparam int FIRST = stage_first_level(s, LVL_PER_STG);
        localparam int NLEV  = stage_num_levels(WIDTH, s, LVL_PER_STG);
        assign lg[s][0] = g_q[s];
        assign lp[s][0] = p_q[s];
        for (genvar j = 0; j < LVL_PER_STG; j++) begin : g_lvl
            localparam int SPAN = (j < NLEV) ? (1 << (FIRST + j)) : 0;
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (j < NLEV && i >= SPAN) begin : g_cell
                    prefix_gp_cell #(.GRAY(i < 2 * SPAN)) u_cell (
                        .g_hi (lg[s][j][i]),
                        .p_hi (lp[s][j][i]),
                        .g_lo (lg[s][j][i-SPAN]),
                        .p_lo (lp[s][j][i-SPAN]),
                        .g_o  (lg[s][j+1][i]),
                        .p_o  (lp[s][j+1][i])
                    );
                end else begin : g_pass
                    assign lg[s][j+1][i] = lg[s][j][i];
                    assign lp[s][j+1][i] = lp[s][j][i];
                end
            end
        end
    end

    // After the last level G[i] is the carry out of bit i.
    assign carry   = lg[NSTG-1][LVL_PER_STG];
    assign sum_fin = pt_q[NSTG-1] ^ {carry[WIDTH-2:0], cin_q[NSTG-1]};

    // Global advance: every stage shifts together or holds together.
    always_comb begin
        v_d    = v_q;
        g_d    = g_q;
        p_d    = p_q;
        pt_d   = pt_q;
        cin_d  = cin_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        if (adv) begin
            v_d      = {v_q[NSTG-1:0], in_valid};
            g_d[0]   = g0;
            p_d[0]   = p0;
            pt_d[0]  = p0;
            cin_d[0] = c_eff;
            for (int s = 1; s < NSTG; s++) begin
                g_d[s]   = lg[s-1][LVL_PER_STG];
                p_d[s]   = lp[s-1][LVL_PER_STG];
                pt_d[s]  = pt_q[s-1];
                cin_d[s] = cin_q[s-1];
            end
            if (v_q[NSTG-1]) begin
                sum_d  = sum_fin;
                cout_d = carry[WIDTH-1];
                ovf_d  = carry[WIDTH-1] ^ carry[WIDTH-2];
            end
        end
    end

    // Valid bits and visible outputs are reset; reset drops in-flight beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            v_q    <= v_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    // Internal data is qualified by v_q, so it needs no reset.
    always_ff @(posedge clk) begin
        g_q   <= g_d;
        p_q   <= p_d;
        pt_q  <= pt_d;
        cin_q <= cin_d;
    end

endmodule
